// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP add/sub issue stage.
// Operation encodings, issue FSM states, sign masks and the flush-to-zero helper.
package fpu_pkg;

   typedef enum logic [1:0] {
      FADD = 2'd0,
      FSUB = 2'd1,
      FNEG = 2'd2,
      FABS = 2'd3
   } addsub_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      BYPASS = 2'd3
   } issue_state_t;

   localparam logic [31:0] SIGN_MASK = 32'h8000_0000;
   localparam logic [31:0] ABS_MASK  = 32'h7FFF_FFFF;

   // Replace a denormal (or zero) single with a signed zero.
   function automatic logic [31:0] ftz(input logic [31:0] v);
      if (v[30:23] == 8'd0) begin
         return {v[31], 31'b0};
      end
      return v;
   endfunction

endpackage

// File: rtl/fpu_addsub_issue_if.sv
// Request/result handshake bundle between the FP dispatch, the issue stage and writeback.
// slave: the issue stage; master: the dispatch/writeback side.
interface fpu_addsub_issue_if #(
   parameter int TAG_W = 4
);
   // request channel
   logic                   req_valid;
   logic                   req_ready;
   fpu_pkg::addsub_op_t    req_op;
   logic [31:0]            req_rs1;
   logic [31:0]            req_rs2;
   logic [TAG_W-1:0]       req_tag;
   // result channel
   logic                   res_valid;
   logic                   res_ready;
   logic [31:0]            res_data;
   logic [TAG_W-1:0]       res_tag;

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_tag, res_ready,
      output req_ready, res_valid, res_data, res_tag
   );

   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_tag, res_ready,
      input  req_ready, res_valid, res_data, res_tag
   );
endinterface

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO with occupancy count.
// Head word is presented combinationally from storage and holds until popped.
module fpu_result_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok  = push & (count != FULL_C);
   assign pop_ok   = pop & (count != '0);
   assign valid    = (count != '0);
   assign pop_data = mem[rd_ptr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fpu_addsub_issue.sv
// Issue/collect stage around the 2-stage fadd unit.
// Accepts FADD/FSUB/FNEG/FABS, keeps one adder op in flight, resolves FNEG/FABS
// locally, and queues tagged results in request order for FP writeback.
// Optional build macro: FPU_FTZ_EN flushes denormal operands and adder results to
// signed zero; without it denormals pass through untouched.
module fpu_addsub_issue
   import fpu_pkg::*;
#(
   parameter int TAG_W     = 4,
   parameter int RES_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rstn,
   fpu_addsub_issue_if.slave   io,
   output logic                fa_order,
   input  logic                fa_accepted,
   input  logic                fa_done,
   output logic [31:0]         fa_rs1,
   output logic [31:0]         fa_rs2,
   input  logic [31:0]         fa_rd
);
   localparam int CW = $clog2(RES_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

   issue_state_t         state;
   addsub_op_t           op_q;
   logic [TAG_W-1:0]     tag_q;
   logic                 accept;
   logic                 is_add;
   logic                 push;
   logic [32+TAG_W-1:0]  push_word;
   logic [32+TAG_W-1:0]  head_word;
   logic                 fifo_valid;
   logic [CW-1:0]        fifo_count;

   // Denormal handling applied to operands on entry and to adder results on return.
   function automatic logic [31:0] flush(input logic [31:0] v);
`ifdef FPU_FTZ_EN
      return ftz(v);
`else
      return v;
`endif
   endfunction

   // Ready only when idle and a FIFO slot is guaranteed; registered count, no pop credit.
   assign io.req_ready = rstn & (state == IDLE) & (fifo_count < DEPTH_C);
   assign accept       = io.req_valid & io.req_ready;
   assign is_add       = (io.req_op == FADD) | (io.req_op == FSUB);

   // Issue FSM: latches the request, drives the adder handshake, tracks the in-flight op.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         fa_order <= 1'b0;
         fa_rs1   <= '0;
         fa_rs2   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q   <= io.req_op;
                  tag_q  <= io.req_tag;
                  fa_rs1 <= flush(io.req_rs1);
                  if (is_add) begin
                     // FSUB becomes an add of the sign-flipped second operand.
                     fa_rs2   <= flush(io.req_rs2) ^
                                 ((io.req_op == FSUB) ? SIGN_MASK : 32'h0);
                     fa_order <= 1'b1;
                     state    <= ISSUE;
                  end else begin
                     state    <= BYPASS;
                  end
               end
            end
            ISSUE: begin
               if (fa_accepted) begin
                  fa_order <= 1'b0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (fa_done) begin
                  state <= IDLE;
               end
            end
            BYPASS: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               fa_order <= 1'b0;
            end
         endcase
      end
   end

   // Result capture: adder rd in the fa_done cycle, or the sign-manipulated operand.
   always_comb begin
      push      = 1'b0;
      push_word = '0;
      case (state)
         WAIT: begin
            if (fa_done) begin
               push      = 1'b1;
               push_word = {flush(fa_rd), tag_q};
            end
         end
         BYPASS: begin
            push      = 1'b1;
            push_word = {((op_q == FNEG) ? (fa_rs1 ^ SIGN_MASK) : (fa_rs1 & ABS_MASK)),
                         tag_q};
         end
         default: begin
            push      = 1'b0;
            push_word = '0;
         end
      endcase
   end

   fpu_result_fifo #(
      .WIDTH (32 + TAG_W),
      .DEPTH (RES_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (push_word),
      .pop       (io.res_ready),
      .pop_data  (head_word),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   assign io.res_valid = fifo_valid;
   assign io.res_data  = head_word[32+TAG_W-1:TAG_W];
   assign io.res_tag   = head_word[TAG_W-1:0];

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Directed bench for fpu_addsub_issue with a behavioural always-idle 2-stage fadd.
module tb_fpu_addsub_issue;
   import fpu_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        fa_order;
   logic        fa_accepted;
   logic        fa_done;
   logic [31:0] fa_rs1;
   logic [31:0] fa_rs2;
   logic [31:0] fa_rd;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   fpu_addsub_issue_if #(.TAG_W(4)) bus ();

   fpu_addsub_issue #(.TAG_W(4), .RES_DEPTH(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .io          (bus),
      .fa_order    (fa_order),
      .fa_accepted (fa_accepted),
      .fa_done     (fa_done),
      .fa_rs1      (fa_rs1),
      .fa_rs2      (fa_rs2),
      .fa_rd       (fa_rd)
   );

   // Hand-computed IEEE sums for the operand pairs used below.
   function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h00000000;
      if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
      if (a == 32'h00000001 && b == 32'h00000001) return 32'h00000002;
      if (a == 32'h00000000 && b == 32'h00000000) return 32'h00000000;
      return 32'h7FC00000;
   endfunction

   // Adder model: accepts immediately, rd valid for one cycle on the following cycle.
   assign fa_accepted = fa_order;
   always @(posedge clk) begin
      if (!rstn) begin
         fa_done <= 1'b0;
         fa_rd   <= 32'hDEADBEEF;
      end else if (fa_order && fa_accepted) begin
         fa_done <= 1'b1;
         fa_rd   <= lookup(fa_rs1, fa_rs2);
      end else begin
         fa_done <= 1'b0;
         fa_rd   <= 32'hDEADBEEF;
      end
   end

   // Adder protocol: done must never coincide with an outstanding order.
   always @(negedge clk) begin
      if (rstn && fa_done && fa_order) begin
         errors++;
         $error("FAIL fa_done_protocol: got order=%0b want 0", fa_order);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %08h want %08h", name, obs, exp);
      end
   endtask

   // Present a request, wait (bounded) for ready, hold through the accepting edge.
   task automatic send(input addsub_op_t op, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [3:0] tag);
      int n;
      n = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rs1   = rs1;
      bus.req_rs2   = rs2;
      bus.req_tag   = tag;
      while (!bus.req_ready && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
   endtask

   // Wait (bounded) for a result, check it, and let it pop on the next edge.
   task automatic expect_result(input string name, input logic [31:0] data,
                                input logic [3:0] tag);
      int n;
      n = 0;
      while (!bus.res_valid && n < 20) begin
         step();
         n++;
      end
      chk({name, "_valid"}, 32'(bus.res_valid), 32'd1);
      chk({name, "_data"}, bus.res_data, data);
      chk({name, "_tag"}, 32'(bus.res_tag), 32'(tag));
      step();
   endtask

   initial begin
      logic [3:0]  tags [5];
      logic        acc;
      int          got;
      int          n;
      logic [31:0] exp_sum;
      logic [31:0] exp_op1;

      rstn          = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = FADD;
      bus.req_rs1   = '0;
      bus.req_rs2   = '0;
      bus.req_tag   = '0;
      bus.res_ready = 1'b1;
      step(); step(); step();

      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_fa_order", 32'(fa_order), 32'd0);
      chk("rst_fa_rs1", fa_rs1, 32'd0);
      chk("rst_fa_rs2", fa_rs2, 32'd0);
      rstn = 1'b1;
      step();
      chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

      // FADD latency: result visible exactly three cycles after acceptance
      send(FADD, 32'h3F800000, 32'h40000000, 4'd5);
      chk("t1_order", 32'(fa_order), 32'd1);
      chk("t1_rs1", fa_rs1, 32'h3F800000);
      chk("t1_rs2", fa_rs2, 32'h40000000);
      chk("t1_valid_T1", 32'(bus.res_valid), 32'd0);
      step();
      chk("t1_valid_T2", 32'(bus.res_valid), 32'd0);
      step();
      chk("t1_valid_T3", 32'(bus.res_valid), 32'd1);
      chk("t1_data", bus.res_data, 32'h40400000);
      chk("t1_tag", 32'(bus.res_tag), 32'd5);
      step();
      chk("t1_popped", 32'(bus.res_valid), 32'd0);

      // FSUB flips rs2 sign before the adder
      send(FSUB, 32'h3F800000, 32'h3F800000, 4'd1);
      chk("t2_rs2_neg", fa_rs2, 32'hBF800000);
      expect_result("t2a", 32'h00000000, 4'd1);
      send(FSUB, 32'h40400000, 32'h3F800000, 4'd2);
      expect_result("t2b", 32'h40000000, 4'd2);

      // FNEG/FABS bypass with two-cycle latency, rs2 don't-care
      send(FNEG, 32'h3F800000, 32'hxxxxxxxx, 4'd3);
      chk("t3_no_order", 32'(fa_order), 32'd0);
      chk("t3_valid_T1", 32'(bus.res_valid), 32'd0);
      step();
      chk("t3_valid_T2", 32'(bus.res_valid), 32'd1);
      chk("t3_neg_data", bus.res_data, 32'hBF800000);
      chk("t3_neg_tag", 32'(bus.res_tag), 32'd3);
      step();
      send(FABS, 32'hC0000000, 32'hxxxxxxxx, 4'd4);
      expect_result("t3_abs", 32'h40000000, 4'd4);

      // Backpressure: four queued results close the request port
      bus.res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(FADD, 32'h3F800000, 32'h40000000, 4'(i));
      end
      step(); step(); step();
      chk("t4_full_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_head_data", bus.res_data, 32'h40400000);
      chk("t4_head_tag", 32'(bus.res_tag), 32'd0);
      bus.req_valid = 1'b1;
      bus.req_op    = FADD;
      bus.req_rs1   = 32'h3F800000;
      bus.req_rs2   = 32'h40000000;
      bus.req_tag   = 4'd4;
      step(); step();
      chk("t4_still_blocked", 32'(bus.req_ready), 32'd0);
      chk("t4_hold_tag", 32'(bus.res_tag), 32'd0);
      bus.res_ready = 1'b1;
      got = 0;
      n   = 0;
      while (got < 5 && n < 60) begin
         acc = bus.req_valid & bus.req_ready;
         if (bus.res_valid) begin
            tags[got] = bus.res_tag;
            chk("t4_data", bus.res_data, 32'h40400000);
            got++;
         end
         step();
         n++;
         if (acc) bus.req_valid = 1'b0;
      end
      chk("t4_count", 32'(got), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < got) chk("t4_order", 32'(tags[i]), 32'(i));
      end
      step(); step(); step();
      chk("t4_no_extra", 32'(bus.res_valid), 32'd0);

      // Denormal operands
`ifdef FPU_FTZ_EN
      exp_sum = 32'h00000000;
      exp_op1 = 32'h00000000;
`else
      exp_sum = 32'h00000002;
      exp_op1 = 32'h00000001;
`endif
      send(FADD, 32'h00000001, 32'h00000001, 4'd6);
      chk("t5_op1", fa_rs1, exp_op1);
      expect_result("t5", exp_sum, 4'd6);

      // Reset while an adder op is in WAIT and another result is queued
      bus.res_ready = 1'b0;
      send(FNEG, 32'h3F800000, 32'hxxxxxxxx, 4'd7);
      step();
      send(FADD, 32'h3F800000, 32'h40000000, 4'd8);
      step();
      rstn = 1'b0;
      step();
      chk("t6_valid_in_rst", 32'(bus.res_valid), 32'd0);
      chk("t6_ready_in_rst", 32'(bus.req_ready), 32'd0);
      chk("t6_order_in_rst", 32'(fa_order), 32'd0);
      rstn = 1'b1;
      bus.res_ready = 1'b1;
      step(); step(); step();
      chk("t6_no_dropped", 32'(bus.res_valid), 32'd0);
      send(FABS, 32'hBF800000, 32'hxxxxxxxx, 4'd9);
      expect_result("t6_after", 32'h3F800000, 4'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
